// File: rtl/el2_exu_alu_sender_if.sv
// Handshake bundle between the ALU result producer and the NoC injection port.
// The slave modport is the sender block's view; master is the surrounding logic.
interface el2_exu_alu_sender_if #(
  parameter int unsigned PACKET_BITS = 128,
  parameter int unsigned FLIT_BITS   = 32
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [PACKET_BITS-1:0] pkt_data;
  logic                   flit_valid;
  logic                   flit_ready;
  logic [FLIT_BITS-1:0]   flit_data;
  logic                   flit_first;
  logic                   flit_last;

  modport master (
    output pkt_valid, pkt_data, flit_ready,
    input  pkt_ready, flit_valid, flit_data, flit_first, flit_last
  );

  modport slave (
    input  pkt_valid, pkt_data, flit_ready,
    output pkt_ready, flit_valid, flit_data, flit_first, flit_last
  );
endinterface

// File: rtl/el2_exu_alu_sender.sv
// Captures one ALU result packet per handshake and serializes it LSB-first into
// NoC flits; supports back-to-back packets, flit backpressure and flush abort.
module el2_exu_alu_sender #(
  parameter int unsigned PACKET_BITS = 128,
  parameter int unsigned FLIT_BITS   = 32,
  parameter int unsigned CNT_BITS    = 8
) (
  input  logic                      clk_noc,
  input  logic                      rst_l,
  input  logic                      noc_sr_flush,
  el2_exu_alu_sender_if.slave       noc,
  output logic                      busy,
  output logic [CNT_BITS-1:0]       abort_cnt
);

  localparam int unsigned NFLITS   = (PACKET_BITS + FLIT_BITS - 1) / FLIT_BITS;
  localparam int unsigned REG_BITS = NFLITS * FLIT_BITS;
  localparam int unsigned IDX_BITS = (NFLITS > 1) ? $clog2(NFLITS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NFLITS - 1);

  logic [0:0]          r_state,     w_state_nxt;
  logic [IDX_BITS-1:0] r_idx,       w_idx_nxt;
  logic [REG_BITS-1:0] r_pkt,       w_pkt_nxt;
  logic [CNT_BITS-1:0] r_abort_cnt, w_abort_nxt;
  logic                r_live;

  logic        w_send;
  logic        w_flit_valid;
  logic        w_is_last;
  logic        w_flit_last;
  logic        w_pkt_ready;
  logic        w_accept;
  logic [31:0] w_shift;

  // Handshake decode; r_live holds pkt_ready low while reset is asserted.
  assign w_send       = (r_state == ST_SEND);
  assign w_flit_valid = w_send & ~noc_sr_flush;
  assign w_is_last    = (r_idx == IDX_LAST);
  assign w_flit_last  = w_flit_valid & w_is_last;
  assign w_pkt_ready  = r_live & ~noc_sr_flush & (~w_send | (w_flit_last & noc.flit_ready));
  assign w_accept     = noc.pkt_valid & w_pkt_ready;
  assign w_shift      = 32'(r_idx) * FLIT_BITS;

  assign noc.pkt_ready  = w_pkt_ready;
  assign noc.flit_valid = w_flit_valid;
  assign noc.flit_first = w_flit_valid & (r_idx == '0);
  assign noc.flit_last  = w_flit_last;
  assign noc.flit_data  = FLIT_BITS'(r_pkt >> w_shift);
  assign busy           = w_send;
  assign abort_cnt      = r_abort_cnt;

  // Next state: flush beats any handshake; a reload on the last flit keeps SEND.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pkt_nxt   = r_pkt;
    w_abort_nxt = r_abort_cnt;
    if (noc_sr_flush) begin
      if (w_send) begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        if (r_abort_cnt != '1) begin
          w_abort_nxt = r_abort_cnt + CNT_BITS'(1);
        end
      end
    end else if (w_accept) begin
      w_pkt_nxt   = REG_BITS'(noc.pkt_data);
      w_idx_nxt   = '0;
      w_state_nxt = ST_SEND;
    end else if (w_flit_valid && noc.flit_ready) begin
      if (w_is_last) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_idx_nxt = r_idx + IDX_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_noc or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_pkt       <= '0;
      r_abort_cnt <= '0;
      r_live      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pkt       <= w_pkt_nxt;
      r_abort_cnt <= w_abort_nxt;
      r_live      <= 1'b1;
    end
  end

endmodule

// File: doc/el2_exu_alu_sender.md
# el2_exu_alu_sender

Upstream NoC injection stage for the EXU ALU result path: captures one full ALU result packet per handshake and serializes it into fixed-width flits on the NoC injection port. It feeds the ALU result receiver across the NoC, which reassembles the same packet layout. Flits leave LSB-first with zero padding in the last flit. The block supports zero-bubble back-to-back packets, flit-level backpressure and a pipeline flush that aborts the packet in flight.

## Interface
Parameters:
- PACKET_BITS, 128: width of the ALU result packet (result, flush bits, flush path, PC, prediction fields).
- FLIT_BITS, 32: NoC flit payload width.
- NFLITS, derived, ceil(PACKET_BITS/FLIT_BITS), ≥1: flits per packet. Not overridable.
- CNT_BITS, 8: width of the abort counter.

Ports:
- clk_noc  in  1  NoC clock; all state on its rising edge.
- rst_l  in  1  reset; asynchronous assert, active-low.
- noc_sr_flush  in  1  flush; aborts any packet in flight.
- pkt_valid  in  1  ALU packet offered.
- pkt_ready  out  1  block accepts the packet this cycle.
- pkt_data  in  PACKET_BITS  packet payload.
- flit_valid  out  1  flit presented to NoC.
- flit_ready  in  1  NoC accepts flit.
- flit_data  out  FLIT_BITS  flit payload.
- flit_first  out  1  current flit is flit 0 of its packet.
- flit_last  out  1  current flit is flit NFLITS-1.
- busy  out  1  a packet is held (state SEND).
- abort_cnt  out  CNT_BITS  saturating count of packets aborted by flush.

## Operation
- State: IDLE, SEND. A packet register is PACKET_BITS+pad wide, zero-padded to NFLITS*FLIT_BITS. The flit index idx is clog2(NFLITS) bits wide, minimum 1.
- Reset values: state IDLE, idx 0, packet register 0, abort_cnt 0. Outputs under reset: flit_valid 0, flit_first 0, flit_last 0, busy 0, pkt_ready 0, flit_data 0.
- pkt_ready = ~noc_sr_flush & (IDLE | (SEND & flit_last & flit_ready)).
- Accept (pkt_valid & pkt_ready):
  - Load the register with zero-extended pkt_data.
  - Set idx to 0 and move to SEND.
- flit_valid = SEND & ~noc_sr_flush.
- flit_data = register slice [idx*FLIT_BITS +: FLIT_BITS].
- flit_first = flit_valid & (idx==0).
- flit_last = flit_valid & (idx==NFLITS-1). With NFLITS=1, first and last are both high.
- Flit handshake (flit_valid & flit_ready):
  - If not last, idx increments.
  - If last and a new packet is accepted the same cycle, reload, stay in SEND, idx 0.
  - If last and no new packet is accepted, go to IDLE.
- Backpressure: while flit_valid & ~flit_ready, flit_data, idx and the register stay stable.
- Flush (noc_sr_flush=1) has priority over every handshake:
  - If SEND: go to IDLE, set idx 0, and increment abort_cnt (saturates at all-ones).
  - If IDLE: no effect.
  - No packet is accepted and no flit is presented while flush is high.
- The register is not cleared on flush. Stale contents are never visible because flit_valid=0 in IDLE.
- Flit order: flit k carries packet bits [k*FLIT_BITS +: FLIT_BITS]. Bits at or above PACKET_BITS are 0.

## Timing
- Accept in cycle N → flit 0 valid in cycle N+1 (one-cycle latency). No combinational path from pkt_data to flit_data.
- With flit_ready held high, a packet occupies exactly NFLITS cycles. Back-to-back packets produce a continuous flit stream with no bubbles.
- pkt_ready depends combinationally on flit_ready and noc_sr_flush. flit_valid depends combinationally on noc_sr_flush only.
- Flush asserted in cycle N: flit_valid drops in cycle N. State is IDLE in N+1. pkt_ready can be high in N+1 if flush has deasserted.
- rst_l low mid-packet: outputs go to their reset values immediately (asynchronous). The partial packet is lost and abort_cnt is not incremented.

## Test plan
- Basic serialization: PACKET_BITS=128, FLIT_BITS=32, pkt_data=0x33333333_22222222_11111111_00000000, flit_ready=1 → flits 0x00000000, 0x11111111, 0x22222222, 0x33333333 in cycles N+1..N+4. flit_first is high only on the first flit, flit_last only on the fourth, and busy drops in N+5.
- Padding: PACKET_BITS=102 (NFLITS=4), pkt_data all ones → flits 0–2 are 0xFFFFFFFF and flit 3 is 0x0000003F.
- Backpressure: flit_ready low for 3 cycles during flit 1 → flit_data holds flit 1's value, pkt_ready=0 throughout, and the packet completes 3 cycles later with no reordering.
- Back-to-back: pkt_valid held high with packets A and B and flit_ready=1 → 8 consecutive valid flits, with B's flit 0 in the cycle right after A's flit 3 and pkt_ready pulsing high on A's last flit.
- Flush mid-packet: assert noc_sr_flush for 1 cycle during flit 2 → flit_valid=0 in that cycle, IDLE next cycle, abort_cnt 0→1. The next packet starts cleanly at flit 0, and a flush while IDLE leaves abort_cnt unchanged.
- Async reset mid-packet: drop rst_l between clock edges during flit 1 → flit_valid, busy and abort_cnt read 0 before the next edge. After release, the first accepted packet serializes correctly.
